// File: rtl/ifu_axi_burst_fetch.sv
// AXI4 read-master fetch unit: one INCR burst of BEATS words per accepted PC, buffered with PCs for decode.
// Optional IFU_ACERR_EN: per-entry inst_err output; an error beat truncates the rest of its burst.
module ifu_axi_burst_fetch #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ID_W       = 4,
  parameter int unsigned FETCH_ID   = 0,
  parameter int unsigned BEATS      = 4,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned GRANT_W    = 2,
  parameter int unsigned GRANT_ID   = 1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [ADDR_W-1:0]  pc,
  input  logic               pc_valid,
  output logic               pc_ready,
  input  logic               flush,
  input  logic [GRANT_W-1:0] grant,
  output logic               irequest,
  output logic [ADDR_W-1:0]  araddr,
  output logic               arvalid,
  input  logic               arready,
  output logic [ID_W-1:0]    arid,
  output logic [7:0]         arlen,
  output logic [2:0]         arsize,
  output logic [1:0]         arburst,
  input  logic [DATA_W-1:0]  rdata,
  input  logic [1:0]         rresp,
  input  logic [ID_W-1:0]    rid,
  input  logic               rlast,
  input  logic               rvalid,
  output logic               rready,
  output logic [DATA_W-1:0]  inst,
  output logic [ADDR_W-1:0]  inst_pc,
  output logic               inst_valid,
  input  logic               inst_ready
`ifdef IFU_ACERR_EN
  ,
  output logic               inst_err
`endif
);

  localparam int unsigned BYTES  = DATA_W / 8;
  localparam int unsigned OFF_W  = $clog2(BYTES);
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ADDR  = 2'd1,
    S_DATA  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [BEAT_W-1:0]   r_beat, w_beat_nxt;
  logic [ADDR_W-1:0]   r_base, w_base_nxt;
  logic                r_arvalid, w_arvalid_nxt;
  logic                r_irequest, w_irequest_nxt;
  logic                r_flushed, w_flushed_nxt;
  logic                w_push, w_pop;
  logic                w_granted, w_rid_ok, w_beat_hs, w_last;
  logic                w_skip_cur, w_beat_err;
  logic [ADDR_W-1:0]   w_beat_pc;
  logic [CNT_W-1:0]    w_free;

  logic [DATA_W-1:0]   r_mem_data [FIFO_DEPTH];
  logic [ADDR_W-1:0]   r_mem_pc   [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]    r_count;

`ifdef IFU_ACERR_EN
  logic                r_skip, w_skip_nxt;
  logic                r_mem_err [FIFO_DEPTH];
  assign w_skip_cur = r_skip;
  assign w_beat_err = (rresp != 2'b00) || (rlast != w_last);
  assign inst_err   = r_mem_err[r_rd_ptr];
`else
  logic                w_unused;
  assign w_skip_cur = 1'b0;
  assign w_beat_err = 1'b0;
  assign w_unused   = ^{rresp, rlast};
`endif

  assign w_granted = (grant == GRANT_W'(GRANT_ID));
  assign w_rid_ok  = (rid == ID_W'(FETCH_ID));
  assign w_last    = (r_beat == BEAT_W'(BEATS - 1));
  assign w_free    = CNT_W'(FIFO_DEPTH) - r_count;
  assign w_beat_pc = r_base + ADDR_W'(r_beat) * ADDR_W'(BYTES);

  assign pc_ready  = (r_state == S_IDLE) && (w_free >= CNT_W'(BEATS)) && !flush;
  assign rready    = ((r_state == S_DATA) || (r_state == S_DRAIN)) && w_granted;
  assign w_beat_hs = rvalid && rready && w_rid_ok;

  assign irequest  = r_irequest;
  assign arvalid   = r_arvalid;
  assign araddr    = r_base;
  assign arid      = ID_W'(FETCH_ID);
  assign arlen     = 8'(BEATS - 1);
  assign arsize    = 3'(OFF_W);
  assign arburst   = 2'b01;

  assign inst_valid = (r_count != '0);
  assign inst       = r_mem_data[r_rd_ptr];
  assign inst_pc    = r_mem_pc[r_rd_ptr];
  assign w_pop      = inst_valid && inst_ready;

  // Fetch sequencing: accept PC, AR handshake (only counts when granted), beat collection / drain
  always_comb begin
    w_state_nxt    = r_state;
    w_beat_nxt     = r_beat;
    w_base_nxt     = r_base;
    w_arvalid_nxt  = r_arvalid;
    w_irequest_nxt = r_irequest;
    w_flushed_nxt  = r_flushed;
    w_push         = 1'b0;
`ifdef IFU_ACERR_EN
    w_skip_nxt     = r_skip;
`endif
    case (r_state)
      S_IDLE: begin
        if (pc_valid && pc_ready) begin
          w_base_nxt     = pc & ~ADDR_W'(BYTES - 1);
          w_state_nxt    = S_ADDR;
          w_arvalid_nxt  = 1'b1;
          w_irequest_nxt = 1'b1;
          w_flushed_nxt  = 1'b0;
          w_beat_nxt     = '0;
`ifdef IFU_ACERR_EN
          w_skip_nxt     = 1'b0;
`endif
        end
      end
      S_ADDR: begin
        if (flush) w_flushed_nxt = 1'b1;
        if (r_arvalid && arready && w_granted) begin
          w_arvalid_nxt = 1'b0;
          w_state_nxt   = (r_flushed || flush) ? S_DRAIN : S_DATA;
        end
      end
      S_DATA: begin
        if (w_beat_hs) begin
          w_beat_nxt = r_beat + BEAT_W'(1);
          w_push     = !flush && !w_skip_cur;
`ifdef IFU_ACERR_EN
          if (w_beat_err) w_skip_nxt = 1'b1;
`endif
          if (w_last) begin
            w_state_nxt    = S_IDLE;
            w_irequest_nxt = 1'b0;
            w_beat_nxt     = '0;
          end else if (flush) begin
            w_state_nxt = S_DRAIN;
          end
        end else if (flush) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_beat_hs) begin
          w_beat_nxt = r_beat + BEAT_W'(1);
          if (w_last) begin
            w_state_nxt    = S_IDLE;
            w_irequest_nxt = 1'b0;
            w_beat_nxt     = '0;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_beat     <= '0;
      r_base     <= '0;
      r_arvalid  <= 1'b0;
      r_irequest <= 1'b0;
      r_flushed  <= 1'b0;
`ifdef IFU_ACERR_EN
      r_skip     <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_beat     <= w_beat_nxt;
      r_base     <= w_base_nxt;
      r_arvalid  <= w_arvalid_nxt;
      r_irequest <= w_irequest_nxt;
      r_flushed  <= w_flushed_nxt;
`ifdef IFU_ACERR_EN
      r_skip     <= w_skip_nxt;
`endif
    end
  end

  // Instruction FIFO; space is reserved at PC accept so a push never sees it full
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        r_mem_data[i] <= '0;
        r_mem_pc[i]   <= '0;
`ifdef IFU_ACERR_EN
        r_mem_err[i]  <= 1'b0;
`endif
      end
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem_data[r_wr_ptr] <= rdata;
        r_mem_pc[r_wr_ptr]   <= w_beat_pc;
`ifdef IFU_ACERR_EN
        r_mem_err[r_wr_ptr]  <= w_beat_err;
`endif
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

endmodule

// File: doc/ifu_axi_burst_fetch.md
Name: ifu_axi_burst_fetch

Overview:
- Parametrised AXI4 read-master instruction fetch unit, successor to the single-beat fetch block.
- Accepts a fetch address from the PC stage and issues one INCR burst of BEATS words, gated by the shared-bus arbiter grant.
- Buffers the returned words with their PCs in an internal FIFO and presents them to the decode stage over a valid/ready handshake.
- Supports pipeline flush with a safe drain of in-flight AXI beats.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, instruction/bus data width; 32 or 64 only.
- ID_W, 4, AXI ID width.
- FETCH_ID, 0, arid value driven; only R beats with rid==FETCH_ID are accepted.
- BEATS, 4, words per burst; 1, 2, 4 or 8.
- FIFO_DEPTH, 8, instruction FIFO entries; power of two, >= BEATS.
- GRANT_W, 2, arbiter grant vector width.
- GRANT_ID, 1, grant value that owns the bus.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- pc  in  ADDR_W  fetch address
- pc_valid  in  1  pc valid
- pc_ready  out  1  unit can accept a new fetch
- flush  in  1  discard all buffered and pending fetches
- grant  in  GRANT_W  arbiter grant
- irequest  out  1  bus request to arbiter
- araddr  out  ADDR_W  burst start address
- arvalid  out  1  AR valid
- arready  in  1  AR ready
- arid  out  ID_W  constant FETCH_ID
- arlen  out  8  constant BEATS-1
- arsize  out  3  constant log2(DATA_W/8)
- arburst  out  2  constant 2'b01 (INCR)
- rdata  in  DATA_W  read data
- rresp  in  2  read response
- rid  in  ID_W  read ID
- rlast  in  1  last beat
- rvalid  in  1  R valid
- rready  out  1  R ready
- inst  out  DATA_W  instruction at FIFO head
- inst_pc  out  ADDR_W  PC of inst
- inst_valid  out  1  FIFO not empty
- inst_ready  in  1  decode accepts inst

Behaviour:
- Clock and reset: one clock, clk; reset resetn is synchronous and active-low.
- Reset: state=IDLE, FIFO empty, beat counter 0.
  - arvalid, rready, irequest and inst_valid are 0.
  - araddr and inst_pc are 0.
  - pc_ready is 1 on the first cycle after reset.
- Reset mid-burst: all state is dropped immediately; orphan beats are system reset's responsibility.
- granted = (grant == GRANT_ID).
- pc_ready = (state==IDLE) && (free FIFO entries >= BEATS) && !flush.
- States and transitions:
  - IDLE: on pc_valid && pc_ready, latch base = pc with the low log2(DATA_W/8) bits cleared. Go to ADDR, and set irequest=1 and arvalid=1 from the next cycle.
  - ADDR: hold arvalid and araddr stable until arvalid && arready && granted; then arvalid=0 next cycle and go to DATA. A handshake without grant is ignored.
  - DATA: rready = granted. Each beat with rvalid && rready && rid==FETCH_ID pushes {rdata, base + beat*DATA_W/8}, and the beat counter increments. When beat==BEATS-1, go to IDLE with irequest=0 and counter=0. Beats with other rid are not accepted.
  - DRAIN: rready = granted. Discard matching beats until beat BEATS-1, then go to IDLE with irequest=0.
- FIFO space is reserved at accept, so a push never meets a full FIFO.
- Push and pop in the same cycle are legal at any occupancy.
- Pop on inst_valid && inst_ready. inst and inst_pc are the head entry, registered and stable while inst_valid && !inst_ready.
- Flush:
  - FIFO cleared on the next cycle, so inst_valid=0.
  - In IDLE: pc is not accepted that cycle.
  - In ADDR: arvalid stays high until the handshake (AXI rule), then go to DRAIN.
  - In DATA: go to DRAIN with the beat count preserved; a beat arriving in the flush cycle is discarded.
- Boundaries:
  - Burst addresses wrap modulo 2^ADDR_W.
  - rlast is not used for termination; the beat count governs.

Optional Feature:
- Macro IFU_ACERR_EN, defined:
  - Adds output inst_err (1 bit), stored per FIFO entry, set when rresp != 2'b00 or when rlast mismatches the beat position.
  - After any error beat in a burst, the remaining beats are discarded and not pushed.
  - inst_err resets to 0.
- Undefined: rresp and rlast are ignored, and every matching beat is pushed.

Test Plan:
- BEATS=4, pc=0x80000006, grant=GRANT_ID, arready=1 -> araddr=0x80000004, arlen=3, arsize=2, arburst=1; rdata 0xA0..0xA3 pop in order with inst_pc 0x80000004/08/0C/10; irequest falls after beat 3.
- grant=0 for 5 cycles with arvalid=1, arready=1 -> no transition; arvalid held until grant=GRANT_ID; rready=0 while ungranted.
- FIFO_DEPTH=8, inst_ready=0, two bursts filled -> pc_ready=0 with 8 entries; one pop frees only 1 entry, so pc_ready stays 0 until 4 free.
- flush asserted after beat 1 of 4 -> DRAIN; beats 2-3 consumed with rready=1, none pushed; inst_valid=0; pc_ready=1 after the final beat.
- Beat with rid=5 (FETCH_ID=0) -> rready handshake not counted, no push; following rid=0 beat is pushed as beat index 0.
- IFU_ACERR_EN: rresp=2'b10 on beat 1 -> entry 0 has inst_err=0, entry 1 has inst_err=1, beats 2-3 discarded; without the macro, all 4 beats are pushed.
